// File: rtl/pseudo_ddr_sched.sv
// AXI4 slave that serializes read and write bursts onto one single-port memory.
// One burst is active at a time; reads are credit-limited into a 4-entry response FIFO.
module pseudo_ddr_sched #(
    parameter int MEM_AW = 20,
    parameter int RD_LAT = 2
) (
    input  logic              pl_clk0,
    input  logic              pl_aresetn,
    input  logic [15:0]       s_awid,
    input  logic [39:0]       s_awaddr,
    input  logic [7:0]        s_awlen,
    input  logic [2:0]        s_awsize,
    input  logic [1:0]        s_awburst,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [127:0]      s_wdata,
    input  logic [15:0]       s_wstrb,
    input  logic              s_wlast,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [15:0]       s_bid,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [15:0]       s_arid,
    input  logic [39:0]       s_araddr,
    input  logic [7:0]        s_arlen,
    input  logic [2:0]        s_arsize,
    input  logic [1:0]        s_arburst,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [15:0]       s_rid,
    output logic [127:0]      s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic              mem_en,
    output logic [15:0]       mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [127:0]      mem_wdata,
    input  logic [127:0]      mem_rdata
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_BURST = 3'd1;
    localparam logic [2:0] ST_WR_RESP  = 3'd2;
    localparam logic [2:0] ST_RD_BURST = 3'd3;
    localparam logic [2:0] ST_RD_DRAIN = 3'd4;

    logic [2:0]        state_reg;
    logic              last_wr_reg;
    logic [15:0]       id_reg;
    logic [7:0]        len_reg;
    logic              fixed_reg;
    logic              err_reg;
    logic              wl_err_reg;
    logic [MEM_AW-1:0] addr_reg;
    logic [7:0]        beat_reg;
    logic [7:0]        out_reg;
    logic [RD_LAT-1:0] vld_pipe_reg;
    logic [2:0]        infl_reg;
    logic [127:0]      fifo_mem [4];
    logic [1:0]        wr_ptr_reg;
    logic [1:0]        rd_ptr_reg;
    logic [2:0]        cnt_reg;

    logic              idle;
    logic              grant_wr;
    logic              grant_rd;
    logic [15:0]       g_id;
    logic [7:0]        g_len;
    logic [1:0]        g_burst;
    logic [2:0]        g_size;
    logic [MEM_AW-1:0] g_addr;
    logic              g_err;
    logic              w_hs;
    logic              w_last_beat;
    logic              issue;
    logic              capture;
    logic              pop;
    logic              unused_addr_bits;

    // Grants are suppressed while reset is held so no ready escapes during reset.
    assign idle     = (state_reg == ST_IDLE) && pl_aresetn;
    assign grant_rd = idle && s_arvalid && (!s_awvalid || last_wr_reg);
    assign grant_wr = idle && s_awvalid && !grant_rd;

    assign s_awready = grant_wr;
    assign s_arready = grant_rd;

    assign g_id    = grant_wr ? s_awid    : s_arid;
    assign g_len   = grant_wr ? s_awlen   : s_arlen;
    assign g_burst = grant_wr ? s_awburst : s_arburst;
    assign g_size  = grant_wr ? s_awsize  : s_arsize;
    assign g_addr  = grant_wr ? s_awaddr[MEM_AW+3:4] : s_araddr[MEM_AW+3:4];
    assign g_err   = g_burst[1] || (g_size != 3'b100);

    assign unused_addr_bits = ^{s_awaddr, s_araddr};

    assign s_wready    = (state_reg == ST_WR_BURST);
    assign w_hs        = s_wready && s_wvalid;
    assign w_last_beat = (beat_reg == len_reg);

    // Credit: reads in the memory pipeline plus FIFO occupancy never exceed the FIFO depth.
    assign issue   = (state_reg == ST_RD_BURST) &&
                     (({1'b0, infl_reg} + {1'b0, cnt_reg}) < 4'd4);
    assign capture = vld_pipe_reg[RD_LAT-1];
    assign pop     = s_rvalid && s_rready;

    assign mem_en    = (w_hs || issue) && !err_reg;
    assign mem_we    = (w_hs && !err_reg) ? s_wstrb : 16'h0000;
    assign mem_addr  = addr_reg;
    assign mem_wdata = s_wdata;

    assign s_bvalid = (state_reg == ST_WR_RESP);
    assign s_bid    = id_reg;
    assign s_bresp  = (err_reg || wl_err_reg) ? 2'b10 : 2'b00;

    assign s_rvalid = (cnt_reg != 3'd0);
    assign s_rid    = id_reg;
    assign s_rdata  = fifo_mem[rd_ptr_reg];
    assign s_rresp  = err_reg ? 2'b10 : 2'b00;
    assign s_rlast  = (out_reg == len_reg);

    always_ff @(posedge pl_clk0 or negedge pl_aresetn) begin
        if (!pl_aresetn) begin
            state_reg    <= ST_IDLE;
            last_wr_reg  <= 1'b1;
            id_reg       <= '0;
            len_reg      <= '0;
            fixed_reg    <= 1'b0;
            err_reg      <= 1'b0;
            wl_err_reg   <= 1'b0;
            addr_reg     <= '0;
            beat_reg     <= '0;
            out_reg      <= '0;
            vld_pipe_reg <= '0;
            infl_reg     <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            cnt_reg      <= '0;
        end else begin
            vld_pipe_reg <= RD_LAT'({vld_pipe_reg, issue});
            infl_reg     <= infl_reg + {2'b00, issue} - {2'b00, capture};
            cnt_reg      <= cnt_reg + {2'b00, capture} - {2'b00, pop};
            if (capture) begin
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
                out_reg    <= out_reg + 8'd1;
            end
            if (w_hs || issue) begin
                addr_reg <= fixed_reg ? addr_reg : addr_reg + MEM_AW'(1);
                beat_reg <= beat_reg + 8'd1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (grant_wr || grant_rd) begin
                        id_reg      <= g_id;
                        len_reg     <= g_len;
                        fixed_reg   <= (g_burst == 2'b00);
                        err_reg     <= g_err;
                        wl_err_reg  <= 1'b0;
                        addr_reg    <= g_addr;
                        beat_reg    <= '0;
                        out_reg     <= '0;
                        last_wr_reg <= grant_wr;
                        state_reg   <= grant_wr ? ST_WR_BURST : ST_RD_BURST;
                    end
                end
                ST_WR_BURST: begin
                    if (w_hs) begin
                        if (s_wlast != w_last_beat) begin
                            wl_err_reg <= 1'b1;
                        end
                        if (w_last_beat) begin
                            state_reg <= ST_WR_RESP;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (s_bready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_RD_BURST: begin
                    if (issue && (beat_reg == len_reg)) begin
                        state_reg <= ST_RD_DRAIN;
                    end
                end
                ST_RD_DRAIN: begin
                    if (pop && s_rlast) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Response data storage; error bursts return zero beats.
    always_ff @(posedge pl_clk0) begin
        if (capture) begin
            fifo_mem[wr_ptr_reg] <= err_reg ? 128'h0 : mem_rdata;
        end
    end

endmodule

// File: tb/tb_pseudo_ddr_sched.sv
// Randomized bench for pseudo_ddr_sched: a behavioural memory image predicts every
// write beat on the memory port and every read beat returned on the R channel.
module tb_pseudo_ddr_sched;

    localparam int MEM_AW = 8;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 256;

    logic         pl_clk0 = 1'b0;
    logic         pl_aresetn = 1'b0;
    logic [15:0]  s_awid = '0;
    logic [39:0]  s_awaddr = '0;
    logic [7:0]   s_awlen = '0;
    logic [2:0]   s_awsize = '0;
    logic [1:0]   s_awburst = '0;
    logic         s_awvalid = 1'b0;
    logic         s_awready;
    logic [127:0] s_wdata = '0;
    logic [15:0]  s_wstrb = '0;
    logic         s_wlast = 1'b0;
    logic         s_wvalid = 1'b0;
    logic         s_wready;
    logic [15:0]  s_bid;
    logic [1:0]   s_bresp;
    logic         s_bvalid;
    logic         s_bready = 1'b0;
    logic [15:0]  s_arid = '0;
    logic [39:0]  s_araddr = '0;
    logic [7:0]   s_arlen = '0;
    logic [2:0]   s_arsize = '0;
    logic [1:0]   s_arburst = '0;
    logic         s_arvalid = 1'b0;
    logic         s_arready;
    logic [15:0]  s_rid;
    logic [127:0] s_rdata;
    logic [1:0]   s_rresp;
    logic         s_rlast;
    logic         s_rvalid;
    logic         s_rready = 1'b0;
    logic         mem_en;
    logic [15:0]  mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;

    always #5 pl_clk0 = ~pl_clk0;

    pseudo_ddr_sched #(.MEM_AW(MEM_AW), .RD_LAT(RD_LAT)) dut (
        .pl_clk0(pl_clk0), .pl_aresetn(pl_aresetn),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [127:0] pat(input int k);
        return {4{32'hC0DE0000 + k}};
    endfunction

    // Physical single-port memory with RD_LAT cycles of read latency.
    logic [127:0] phys_mem [DEPTH];
    logic [127:0] rd_pipe [RD_LAT];
    logic         init_en = 1'b0;
    int           init_idx = 0;

    always @(posedge pl_clk0) begin
        if (init_en) begin
            if (init_idx < DEPTH) begin
                phys_mem[init_idx] <= pat(init_idx);
                init_idx <= init_idx + 1;
            end
        end else if (mem_en) begin
            if (mem_we != 16'h0) begin
                for (int b = 0; b < 16; b++)
                    if (mem_we[b]) phys_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                rd_pipe[0] <= phys_mem[mem_addr];
            end
        end
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    // Reference model state.
    logic [127:0] ref_mem [DEPTH];
    int n_chk = 0;
    int n_pass = 0;

    logic [15:0] w_id, r_id;
    int          w_addr, w_len, r_addr, r_len;
    logic [1:0]  w_burst, r_burst;
    logic [2:0]  w_size, r_size;
    bit          w_badlast = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_aw(input logic [15:0] id, input int wa, input int len,
                          input logic [1:0] burst, input logic [2:0] size);
        w_id = id; w_addr = wa; w_len = len; w_burst = burst; w_size = size;
        s_awid = id;
        s_awaddr = {28'($urandom), 8'(wa), 4'($urandom)};
        s_awlen = 8'(len); s_awburst = burst; s_awsize = size; s_awvalid = 1'b1;
    endtask

    task automatic set_ar(input logic [15:0] id, input int ra, input int len,
                          input logic [1:0] burst, input logic [2:0] size);
        r_id = id; r_addr = ra; r_len = len; r_burst = burst; r_size = size;
        s_arid = id;
        s_araddr = {28'($urandom), 8'(ra), 4'($urandom)};
        s_arlen = 8'(len); s_arburst = burst; s_arsize = size; s_arvalid = 1'b1;
    endtask

    // Returns 1 for a write grant, 2 for a read grant; leaves time at the cycle after grant.
    task automatic wait_grant(output int which);
        which = 0;
        for (int c = 0; c < 200 && which == 0; c++) begin
            @(negedge pl_clk0);
            if (s_awready && s_arready) which = 3;
            else if (s_awready) which = 1;
            else if (s_arready) which = 2;
            @(posedge pl_clk0); #1;
            if (which == 1) s_awvalid = 1'b0;
            if (which == 2) s_arvalid = 1'b0;
        end
        chk("grant_seen", (which == 1 || which == 2), 1);
    endtask

    task automatic wr_data(input int abort_after);
        int ea = w_addr;
        bit err = (w_burst[1] == 1'b1) || (w_size != 3'b100);
        bit wl_err = 0;
        int beat = 0;
        int cyc = 0;
        bit aborted = 0;
        bit got = 0;
        logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
        logic [15:0]  st = 16'($urandom_range(1, 65535));
        while (beat <= w_len && cyc < 400 && !aborted) begin
            s_wvalid = ($urandom_range(0, 3) != 0);
            s_wdata = d; s_wstrb = st;
            s_wlast = (beat == w_len) ^ (w_badlast && beat == 0);
            @(negedge pl_clk0);
            if (cyc == 0) chk("w_ready_lat1", s_wready, 1);
            if (s_wvalid && s_wready) begin
                chk("w_mem_en", mem_en, !err);
                if (!err) begin
                    chk("w_mem_addr", mem_addr, ea);
                    chk("w_mem_we", mem_we, st);
                    chk("w_mem_wdata", mem_wdata, d);
                    for (int b = 0; b < 16; b++)
                        if (st[b]) ref_mem[ea][8*b +: 8] = d[8*b +: 8];
                end
                if (s_wlast != (beat == w_len)) wl_err = 1;
                if (w_burst != 2'b00) ea = (ea + 1) % DEPTH;
                beat++;
                d = {$urandom, $urandom, $urandom, $urandom};
                st = 16'($urandom_range(1, 65535));
                if (abort_after != 0 && beat == abort_after) aborted = 1;
            end else begin
                chk("w_idle_mem_en", mem_en, 0);
            end
            @(posedge pl_clk0); #1;
            cyc++;
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        if (aborted) return;
        chk("w_all_beats", (beat > w_len), 1);
        for (int c = 0; c < 100 && !got; c++) begin
            s_bready = ($urandom_range(0, 1) == 1);
            @(negedge pl_clk0);
            if (s_bvalid && s_bready) begin
                chk("b_id", s_bid, w_id);
                chk("b_resp", s_bresp, (err || wl_err) ? 2'b10 : 2'b00);
                got = 1;
            end
            @(posedge pl_clk0); #1;
        end
        s_bready = 1'b0;
        chk("b_seen", got, 1);
    endtask

    // mode 0: random rready, 1: toggling 1/0, 2: always ready.
    task automatic rd_data(input int mode);
        int ea = r_addr;
        bit err = (r_burst[1] == 1'b1) || (r_size != 3'b100);
        int beat = 0;
        int cyc = 1;
        bit first_seen = 0;
        int en_bad = 0;
        bit tog = 1;
        logic [127:0] exp;
        while (beat <= r_len && cyc < 600) begin
            case (mode)
                0: s_rready = ($urandom_range(0, 1) == 1);
                1: begin s_rready = tog; tog = ~tog; end
                default: s_rready = 1'b1;
            endcase
            @(negedge pl_clk0);
            if (err && mem_en) en_bad++;
            if (s_rvalid && !first_seen) begin
                first_seen = 1;
                chk("r_first_latency", cyc, RD_LAT + 2);
            end
            if (s_rvalid && s_rready) begin
                exp = err ? 128'h0 : ref_mem[ea];
                chk("r_data", s_rdata, exp);
                chk("r_id", s_rid, r_id);
                chk("r_resp", s_rresp, err ? 2'b10 : 2'b00);
                chk("r_last", s_rlast, (beat == r_len));
                if (r_burst != 2'b00) ea = (ea + 1) % DEPTH;
                beat++;
            end
            @(posedge pl_clk0); #1;
            cyc++;
        end
        s_rready = 1'b0;
        chk("r_all_beats", (beat > r_len), 1);
        if (err) chk("r_err_no_mem", en_bad, 0);
    endtask

    initial begin
        int which;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = pat(k);

        // Reset: memory image loads while outputs must stay quiet.
        init_en = 1'b1;
        s_awvalid = 1'b1; s_arvalid = 1'b1;
        repeat (DEPTH + 4) @(posedge pl_clk0);
        @(negedge pl_clk0);
        chk("rst_awready", s_awready, 0);
        chk("rst_arready", s_arready, 0);
        chk("rst_valids", {s_wready, s_bvalid, s_rvalid}, 3'b000);
        chk("rst_mem", {mem_en, mem_we}, 17'h0);
        @(posedge pl_clk0); #1;
        s_awvalid = 1'b0; s_arvalid = 1'b0; init_en = 1'b0;
        pl_aresetn = 1'b1;
        @(posedge pl_clk0); #1;

        // Simultaneous requests alternate starting with read.
        for (int rep = 0; rep < 2; rep++) begin
            set_aw(16'h21 + 16'(rep), 8'h40 + rep * 4, 1, 2'b01, 3'b100);
            set_ar(16'h31 + 16'(rep), 8'h50 + rep * 4, 1, 2'b01, 3'b100);
            wait_grant(which);
            chk("order_read", which, 2);
            rd_data(2);
            wait_grant(which);
            chk("order_write", which, 1);
            wr_data(0);
        end
        set_ar(16'h77, 8'h60, 0, 2'b01, 3'b100);
        wait_grant(which);
        rd_data(2);
        set_aw(16'h78, 8'h61, 0, 2'b01, 3'b100);
        set_ar(16'h79, 8'h62, 0, 2'b01, 3'b100);
        wait_grant(which);
        chk("tie_after_read", which, 1);
        wr_data(0);
        wait_grant(which);
        rd_data(0);

        // Directed INCR write/read of four beats at byte address 0x100.
        set_aw(16'h12, 8'h10, 3, 2'b01, 3'b100);
        wait_grant(which);
        wr_data(0);
        set_ar(16'h05, 8'h10, 3, 2'b01, 3'b100);
        wait_grant(which);
        rd_data(1);

        // Address wrap at the top of the memory.
        set_aw(16'h0A, DEPTH - 1, 1, 2'b01, 3'b100);
        wait_grant(which);
        wr_data(0);
        set_ar(16'h0B, DEPTH - 1, 1, 2'b01, 3'b100);
        wait_grant(which);
        rd_data(0);

        // Error bursts and wlast mismatch.
        set_ar(16'h0C, 8'h20, 1, 2'b10, 3'b100);
        wait_grant(which);
        rd_data(0);
        set_aw(16'h0D, 8'h22, 2, 2'b11, 3'b100);
        wait_grant(which);
        wr_data(0);
        set_aw(16'h0E, 8'h24, 1, 2'b01, 3'b011);
        wait_grant(which);
        wr_data(0);
        w_badlast = 1;
        set_aw(16'h0F, 8'h26, 2, 2'b01, 3'b100);
        wait_grant(which);
        wr_data(0);
        w_badlast = 0;

        // FIXED burst collapses onto one word.
        set_aw(16'h33, 8'h30, 3, 2'b00, 3'b100);
        wait_grant(which);
        wr_data(0);
        set_ar(16'h34, 8'h30, 2, 2'b00, 3'b100);
        wait_grant(which);
        rd_data(0);

        // Reset in the middle of a long write abandons it.
        set_aw(16'h44, 8'h80, 7, 2'b01, 3'b100);
        wait_grant(which);
        wr_data(2);
        pl_aresetn = 1'b0;
        @(negedge pl_clk0);
        chk("mid_rst_quiet", {s_wready, s_bvalid, mem_en}, 3'b000);
        repeat (2) @(posedge pl_clk0);
        #1 pl_aresetn = 1'b1;
        repeat (3) begin
            @(negedge pl_clk0);
            chk("post_rst_idle", {s_wready, s_bvalid, s_rvalid}, 3'b000);
        end
        @(posedge pl_clk0); #1;
        set_ar(16'h45, 8'h80, 7, 2'b01, 3'b100);
        wait_grant(which);
        chk("post_rst_ar", which, 2);
        rd_data(0);

        // Randomized traffic.
        for (int t = 0; t < 25; t++) begin
            bit is_wr = ($urandom_range(0, 1) == 1);
            int sel = $urandom_range(0, 9);
            logic [1:0] bu = (sel == 0) ? 2'b10 : (sel < 4) ? 2'b00 : 2'b01;
            logic [2:0] sz = (sel == 1) ? 3'b011 : 3'b100;
            int a = $urandom_range(0, DEPTH - 1);
            int l = $urandom_range(0, 7);
            logic [15:0] id = 16'($urandom);
            if (is_wr) begin
                w_badlast = ($urandom_range(0, 7) == 0);
                set_aw(id, a, l, bu, sz);
            end else begin
                set_ar(id, a, l, bu, sz);
            end
            wait_grant(which);
            chk("rand_grant", which, is_wr ? 1 : 2);
            if (is_wr) wr_data(0);
            else rd_data(0);
            w_badlast = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
